// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge (dmem_bridge).
package dmem_pkg;

  localparam int         BEAT_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    MW_NONE  = 2'b00,
    MW_BYTE  = 2'b01,
    MW_WORD  = 2'b10,
    MW_DWORD = 2'b11
  } mw_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RLO  = 2'b01,
    S_RHI  = 2'b10,
    S_WHI  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    LD_BYTE  = 2'b00,
    LD_WORD  = 2'b01,
    LD_DWORD = 2'b10
  } ld_e;

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side request bus plus RAM-side beat bus of the data-memory bridge.
interface dmem_bridge_if
  import dmem_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 12
) ();

  // Flow control: a request is presented on adr/wdata/memwrite/rd_en/dword/rd_byte
  // and must be held unchanged while stall=1; the access retires in the first
  // cycle where stall=0. The RAM has no handshake: ram_rdata answers ram_addr
  // one cycle later, and a write happens on every edge with ram_we=1.
  logic [N-1:0]      adr;
  logic [N-1:0]      wdata;
  logic [1:0]        memwrite;
  logic              rd_en;
  logic              dword;
  logic              rd_byte;
  logic [N-1:0]      rdata;
  logic              stall;
  logic              misalign;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [BEAT_W-1:0] ram_wdata;
  logic [BEAT_W-1:0] ram_rdata;
  state_e            dbg_state;

  modport master (
    output adr, wdata, memwrite, rd_en, dword, rd_byte, ram_rdata,
    input  rdata, stall, misalign, ram_addr, ram_we, ram_be, ram_wdata, dbg_state
  );

  modport slave (
    input  adr, wdata, memwrite, rd_en, dword, rd_byte, ram_rdata,
    output rdata, stall, misalign, ram_addr, ram_we, ram_be, ram_wdata, dbg_state
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering between the core and a 32-bit little-endian RAM beat.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic              st_byte,
  input  logic [1:0]        st_lane,
  input  logic [BEAT_W-1:0] st_data,
  output logic [3:0]        be,
  output logic [BEAT_W-1:0] wdata_out,
  input  logic              ld_byte,
  input  logic [1:0]        ld_lane,
  input  logic [BEAT_W-1:0] ram_rdata,
  output logic [BEAT_W-1:0] ld_val
);

  always_comb begin
    be        = BE_ALL;
    wdata_out = st_data;
    if (st_byte) begin
      be        = 4'b0001 << st_lane;
      wdata_out = {4{st_data[7:0]}};
    end
  end

  always_comb begin
    ld_val = ram_rdata;
    if (ld_byte) begin
      ld_val = {24'b0, ram_rdata[8*ld_lane +: 8]};
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage bridge: byte/word/dword core accesses onto a 32-bit synchronous RAM.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 12
) (
  input logic clk,
  input logic reset,
  dmem_bridge_if.slave bus
);

  mw_e               mw;
  logic              wr_req;
  logic              rd_req;
  ld_e               ld_kind;
  logic [AW-1:0]     base_addr;
  logic              bad_now;

  state_e            state;
  logic [AW-1:0]     req_addr;
  logic [AW-1:0]     hi_addr;
  logic [BEAT_W-1:0] req_hi;
  ld_e               req_kind;
  logic [1:0]        req_lane;
  logic              req_bad;
  logic [BEAT_W-1:0] lo_q;
  logic [N-1:0]      rdata_q;
  logic [N-1:0]      done_val;

  logic [3:0]        st_be;
  logic [BEAT_W-1:0] st_wdata;
  logic [BEAT_W-1:0] ld_val;
  logic              unused_adr_hi;

  assign mw            = mw_e'(bus.memwrite);
  assign wr_req        = (mw != MW_NONE);
  assign rd_req        = bus.rd_en && !wr_req;
  assign ld_kind       = bus.dword ? LD_DWORD : (bus.rd_byte ? LD_BYTE : LD_WORD);
  assign base_addr     = bus.adr[AW+1:2];
  assign hi_addr       = req_addr + AW'(1);
  assign unused_adr_hi = ^bus.adr[N-1:AW+2];
  assign bus.dbg_state = state;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic conflict;
  logic misalign_q;

  assign conflict = bus.rd_en && wr_req;

  always_comb begin
    bad_now = 1'b0;
    if (wr_req) begin
      bad_now = ((mw == MW_WORD) && (bus.adr[1:0] != 2'b00)) ||
                ((mw == MW_DWORD) && (bus.adr[2:0] != 3'b000));
    end else if (rd_req) begin
      bad_now = ((ld_kind == LD_WORD) && (bus.adr[1:0] != 2'b00)) ||
                ((ld_kind == LD_DWORD) && (bus.adr[2:0] != 3'b000));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if ((state == S_IDLE) && (wr_req || rd_req) && (bad_now || conflict)) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.misalign = misalign_q;
`else
  // Sub-word address bits are simply dropped: ram_addr never sees them.
  assign bad_now      = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  dmem_lane u_lane (
    .st_byte   (mw == MW_BYTE),
    .st_lane   (bus.adr[1:0]),
    .st_data   (bus.wdata[BEAT_W-1:0]),
    .be        (st_be),
    .wdata_out (st_wdata),
    .ld_byte   (req_kind == LD_BYTE),
    .ld_lane   (req_lane),
    .ram_rdata (bus.ram_rdata),
    .ld_val    (ld_val)
  );

  // A trapped load completes on normal timing but returns zero.
  always_comb begin
    done_val = N'(ld_val);
    if (req_bad) begin
      done_val = '0;
    end else if (state == S_RHI) begin
      done_val = N'({bus.ram_rdata, lo_q});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      req_addr <= '0;
      req_hi   <= '0;
      req_kind <= LD_WORD;
      req_lane <= '0;
      req_bad  <= 1'b0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_req) begin
            req_addr <= base_addr;
            req_hi   <= bus.wdata[N-1:N-BEAT_W];
            req_bad  <= bad_now;
            if (mw == MW_DWORD) state <= S_WHI;
          end else if (rd_req) begin
            req_addr <= base_addr;
            req_kind <= ld_kind;
            req_lane <= bus.adr[1:0];
            req_bad  <= bad_now;
            state    <= S_RLO;
          end
        end
        S_RLO: begin
          if (req_kind == LD_DWORD) begin
            lo_q  <= bus.ram_rdata;
            state <= S_RHI;
          end else begin
            rdata_q <= done_val;
            state   <= S_IDLE;
          end
        end
        S_RHI: begin
          rdata_q <= done_val;
          state   <= S_IDLE;
        end
        S_WHI:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion states drive only from the latched request, never from the core inputs.
  always_comb begin
    bus.ram_addr  = base_addr;
    bus.ram_we    = 1'b0;
    bus.ram_be    = BE_ALL;
    bus.ram_wdata = st_wdata;
    bus.stall     = 1'b0;
    bus.rdata     = rdata_q;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (wr_req) begin
            bus.ram_we = !bad_now;
            bus.ram_be = st_be;
            bus.stall  = (mw == MW_DWORD);
          end else if (rd_req) begin
            bus.stall = 1'b1;
          end
        end
        S_RLO: begin
          bus.ram_addr = req_addr;
          if (req_kind == LD_DWORD) begin
            bus.ram_addr = hi_addr;
            bus.stall    = 1'b1;
          end else begin
            bus.rdata = done_val;
          end
        end
        S_RHI: begin
          bus.ram_addr = hi_addr;
          bus.rdata    = done_val;
        end
        S_WHI: begin
          bus.ram_addr  = hi_addr;
          bus.ram_we    = !req_bad;
          bus.ram_be    = BE_ALL;
          bus.ram_wdata = req_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge against a byte-addressed memory model.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int N     = 64;
  localparam int AW    = 12;
  localparam int BYTES = 4 << AW;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_bridge_if #(.N(N), .AW(AW)) bus ();

  dmem_bridge #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- synchronous RAM ----------------
  logic [31:0] ram [1<<AW];

  always @(posedge clk) begin
    if (bus.ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_be[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_mem [BYTES];
  logic [63:0] exp_q[$];
  logic [63:0] last_rd;
  bit          exp_mis;
  int          errors = 0;
  int          checks = 0;

  function automatic bit is_bad(logic [1:0] mw, bit rd, bit dw, bit rb, logic [63:0] a);
    if (!TRAP) return 1'b0;
    if (mw == 2'b10) return a[1:0] != 2'b00;
    if (mw == 2'b11) return a[2:0] != 3'b000;
    if (mw == 2'b00 && rd) begin
      if (dw) return a[2:0] != 3'b000;
      if (!rb) return a[1:0] != 2'b00;
    end
    return 1'b0;
  endfunction

  function automatic bit is_conflict(logic [1:0] mw, bit rd);
    return TRAP && rd && (mw != 2'b00);
  endfunction

  function automatic int exp_cycles(logic [1:0] mw, bit dw);
    if (mw == 2'b11) return 2;
    if (mw != 2'b00) return 1;
    return dw ? 3 : 2;
  endfunction

  task automatic model_store(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] wd);
    int b = int'(a[AW+1:0]);
    int w = b & ~3;
    int h = (w + 4) % BYTES;
    if (mw == 2'b01) ref_mem[b] = wd[7:0];
    if (mw != 2'b01) for (int i = 0; i < 4; i++) ref_mem[w+i] = wd[8*i +: 8];
    if (mw == 2'b11) for (int i = 0; i < 4; i++) ref_mem[h+i] = wd[32+8*i +: 8];
  endtask

  function automatic logic [63:0] model_load(bit dw, bit rb, logic [63:0] a);
    int b = int'(a[AW+1:0]);
    int w = b & ~3;
    int h = (w + 4) % BYTES;
    logic [31:0] lo, hi;
    if (!dw && rb) return {56'b0, ref_mem[b]};
    lo = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    hi = {ref_mem[h+3], ref_mem[h+2], ref_mem[h+1], ref_mem[h]};
    if (!dw) return {32'b0, lo};
    return {hi, lo};
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive_req(input logic [1:0] mw, input bit rd, input bit dw, input bit rb,
                           input logic [63:0] a, input logic [63:0] wd);
    bus.memwrite = mw;
    bus.rd_en    = rd;
    bus.dword    = dw;
    bus.rd_byte  = rb;
    bus.adr      = a;
    bus.wdata    = wd;
  endtask

  task automatic drive_idle();
    bus.memwrite = 2'b00;
    bus.rd_en    = 1'b0;
    bus.dword    = 1'b0;
    bus.rd_byte  = 1'b0;
  endtask

  task automatic do_access(input logic [1:0] mw, input bit rd, input bit dw, input bit rb,
                           input logic [63:0] a, input logic [63:0] wd,
                           output int cyc, output logic [63:0] got);
    drive_req(mw, rd, dw, rb, a, wd);
    cyc = 0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      got = bus.rdata;
      if (!bus.stall) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_req(2'b11, 1'b1, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", bus.ram_we); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();
    exp_mis = 1'b0;
    last_rd = '0;
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
    checks++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%0b exp=0", bus.misalign); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall got=%0b exp=0", bus.stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_store();
    drive_req(2'b01, 1'b0, 1'b0, 1'b0, 64'h13, 64'hAB);
    @(negedge clk);
    checks++; if (bus.ram_be !== 4'b1000) begin errors++; $display("FAIL bstore_be got=%b exp=1000", bus.ram_be); end
    checks++; if (bus.ram_wdata !== 32'hABABABAB) begin errors++; $display("FAIL bstore_wdata got=%h exp=ababab ab", bus.ram_wdata); end
    checks++; if (bus.ram_addr !== 12'd4) begin errors++; $display("FAIL bstore_addr got=%0d exp=4", bus.ram_addr); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL bstore_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL bstore_we got=%0b exp=1", bus.ram_we); end
    model_store(2'b01, 64'h13, 64'hAB);
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_dword_store();
    drive_req(2'b11, 1'b0, 1'b0, 1'b0, 64'h20, 64'h11223344_55667788);
    @(negedge clk);
    checks++; if (bus.ram_addr !== 12'd8) begin errors++; $display("FAIL dstore_c0_addr got=%0d exp=8", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h55667788) begin errors++; $display("FAIL dstore_c0_data got=%h exp=55667788", bus.ram_wdata); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL dstore_c0_stall got=%0b exp=1", bus.stall); end
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL dstore_c0_we got=%0b exp=1", bus.ram_we); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.ram_addr !== 12'd9) begin errors++; $display("FAIL dstore_c1_addr got=%0d exp=9", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h11223344) begin errors++; $display("FAIL dstore_c1_data got=%h exp=11223344", bus.ram_wdata); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL dstore_c1_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL dstore_c1_we got=%0b exp=1", bus.ram_we); end
    model_store(2'b11, 64'h20, 64'h11223344_55667788);
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_dword_load();
    logic [2:0]  st;
    logic [63:0] exp;
    exp = model_load(1'b1, 1'b0, 64'h20);
    drive_req(2'b00, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      st[c] = bus.stall;
      if (c == 2) begin
        checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL dload_c2_rdata got=%h exp=%h", bus.rdata, exp); end
      end
      @(posedge clk); #1;
    end
    drive_idle();
    checks++; if (st !== 3'b011) begin errors++; $display("FAIL dload_stall_seq got=%b exp=011 (c2..c0)", st); end
    checks++; if (exp !== 64'h11223344_55667788) begin errors++; $display("FAIL dload_model got=%h exp=1122334455667788", exp); end
    @(negedge clk);
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL dload_held got=%h exp=%h", bus.rdata, exp); end
    last_rd = exp;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [63:0] a = 64'((2**AW - 1) * 4);
    logic [63:0] wd = 64'hCAFEF00D_01234567;
    bit bad = is_bad(2'b11, 1'b0, 1'b0, 1'b0, a);
    int cyc;
    logic [63:0] got, exp;
    drive_req(2'b11, 1'b0, 1'b0, 1'b0, a, wd);
    @(negedge clk);
    checks++; if (bus.ram_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_c0_addr got=%h exp=fff", bus.ram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.ram_addr !== 12'h000) begin errors++; $display("FAIL wrap_c1_addr got=%h exp=000", bus.ram_addr); end
    checks++; if (bus.ram_we !== !bad) begin errors++; $display("FAIL wrap_c1_we got=%0b exp=%0b", bus.ram_we, !bad); end
    @(posedge clk); #1;
    drive_idle();
    exp_mis |= bad;
    if (!bad) model_store(2'b11, a, wd);
    exp = model_load(1'b0, 1'b0, 64'h0);
    do_access(2'b00, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, cyc, got);
    checks++; if (got !== exp) begin errors++; $display("FAIL wrap_readback got=%h exp=%h", got, exp); end
    last_rd = exp;
  endtask

  task automatic test_misalign();
    logic [63:0] a = 64'h6;
    logic [63:0] wd = 64'h0000_0000_DEAD_BEEF;
    bit bad = is_bad(2'b10, 1'b0, 1'b0, 1'b0, a);
    int cyc;
    logic [63:0] got, exp;
    drive_req(2'b10, 1'b0, 1'b0, 1'b0, a, wd);
    @(negedge clk);
    checks++; if (bus.ram_we !== !bad) begin errors++; $display("FAIL mis_we got=%0b exp=%0b", bus.ram_we, !bad); end
    checks++; if (bus.ram_addr !== 12'd1) begin errors++; $display("FAIL mis_addr got=%0d exp=1", bus.ram_addr); end
    checks++; if (bus.ram_be !== 4'hF) begin errors++; $display("FAIL mis_be got=%h exp=f", bus.ram_be); end
    checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL mis_flag_c0 got=%0b exp=%0b", bus.misalign, exp_mis); end
    @(posedge clk); #1;
    drive_idle();
    if (!bad) model_store(2'b10, a, wd);
    exp_mis |= bad;
    @(negedge clk);
    checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL mis_flag_c1 got=%0b exp=%0b", bus.misalign, exp_mis); end
    exp = model_load(1'b0, 1'b0, 64'h4);
    @(posedge clk); #1;
    do_access(2'b00, 1'b1, 1'b0, 1'b0, 64'h4, 64'h0, cyc, got);
    checks++; if (got !== exp) begin errors++; $display("FAIL mis_readback got=%h exp=%h", got, exp); end
    last_rd = exp;
    @(negedge clk);
    checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL mis_sticky got=%0b exp=%0b", bus.misalign, exp_mis); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int          k = $urandom_range(0, 6);
      int          base = $urandom_range(0, 47);
      logic [1:0]  mw = 2'b00;
      bit          rd = 1'b0, dw = 1'b0, rb = 1'b0, bad;
      logic [63:0] a = {$urandom(), $urandom()};
      logic [63:0] wd = {$urandom(), $urandom()};
      logic [63:0] got, exp;
      int          cyc;
      if ($urandom_range(0, 3) == 0) base += BYTES - 24;
      a[AW+1:0] = base[AW+1:0];
      case (k)
        0: mw = 2'b01;
        1: mw = 2'b10;
        2: mw = 2'b11;
        3: begin rd = 1'b1; rb = 1'b1; dw = 1'($urandom_range(0, 1)) & 1'b0; end
        4: rd = 1'b1;
        5: begin rd = 1'b1; dw = 1'b1; rb = 1'($urandom_range(0, 1)); end
        default: begin mw = 2'($urandom_range(1, 3)); rd = 1'b1; dw = 1'($urandom_range(0, 1)); end
      endcase
      bad = is_bad(mw, rd, dw, rb, a);
      if (mw == 2'b00) exp_q.push_back(bad ? 64'h0 : model_load(dw, rb, a));
      else if (!bad) model_store(mw, a, wd);
      do_access(mw, rd, dw, rb, a, wd, cyc, got);
      exp_mis |= bad | is_conflict(mw, rd);
      checks++;
      if (cyc !== exp_cycles(mw, (mw == 2'b00) && dw)) begin
        errors++; $display("FAIL rnd_cycles t=%0d kind=%0d got=%0d exp=%0d", t, k, cyc, exp_cycles(mw, dw));
      end
      if (mw == 2'b00) begin
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL rnd_load t=%0d adr=%h dw=%0b rb=%0b got=%h exp=%h", t, a, dw, rb, got, exp); end
        last_rd = exp;
      end
      @(negedge clk);
      checks++; if (bus.rdata !== last_rd) begin errors++; $display("FAIL rnd_hold t=%0d got=%h exp=%h", t, bus.rdata, last_rd); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign got=%0b exp=%0b", bus.misalign, exp_mis); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    drive_req(2'b00, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rmid_c0_stall got=%0b exp=1", bus.stall); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rmid_rst_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rmid_rst_we got=%0b exp=0", bus.ram_we); end
    checks++; if (bus.ram_addr === 12'd9) begin errors++; $display("FAIL rmid_rst_addr got=%0d exp=not 9", bus.ram_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();
    exp_mis = 1'b0;
    last_rd = '0;
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL rmid_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.ram_addr === 12'd9) begin errors++; $display("FAIL rmid_addr got=%0d exp=not 9", bus.ram_addr); end
    checks++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL rmid_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.misalign !== exp_mis) begin errors++; $display("FAIL rmid_misalign got=%0b exp=%0b", bus.misalign, exp_mis); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h0;
    bus.ram_rdata = 32'h0;
    bus.adr       = '0;
    bus.wdata     = '0;
    drive_idle();
    test_reset();
    test_byte_store();
    test_dword_store();
    test_dword_load();
    test_wrap();
    test_misalign();
    test_random(300);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
